instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the number of output buffer entries (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port r_addr_imem  output  32  fetch address to instruction memory; always equals the internal fetch PC.
REQ-006 SHALL have port r_data_imem  input  32  instruction word returned combinationally, same cycle, for r_addr_imem.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_pc  input  32  redirect target.
REQ-009 SHALL have port out_valid  output  1  buffer head holds a valid instruction.
REQ-010 SHALL have port out_ready  input  1  decode accepts the head this cycle.
REQ-011 SHALL have port out_instr  output  32  head instruction word.
REQ-012 SHALL have port out_pc  output  32  address of out_instr.
REQ-013 SHALL have port fault  output  1  misaligned redirect trapped; fetching halted.

Function
REQ-014 SHALL implement states RUN and FAULT; rst forces RUN.
REQ-015 In RUN, SHALL fetch (push {pc, r_data_imem} into the buffer and set pc <= pc+4) in every cycle where the buffer is not full, or is full and a pop occurs in the same cycle.
REQ-016 SHALL hold pc and perform no push when the buffer is full and there is no pop.
REQ-017 SHALL define a pop as out_valid && out_ready.
REQ-018 SHALL have fetch-to-output latency of 1 cycle: a word pushed in cycle N appears at the head with out_valid=1 in cycle N+1 if the buffer was empty.
REQ-019 SHALL keep out_instr and out_pc stable while out_valid=1 and out_ready=0.
REQ-020 SHALL wrap the PC modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000), with no flag raised.
REQ-021 On redirect_valid with redirect_pc[1:0]==0, SHALL: flush the buffer, discard the current-cycle fetch, and set pc <= redirect_pc. The out_valid signal is 0 in cycle N+1 and the target word is at the head in cycle N+2.
REQ-022 On a simultaneous redirect and pop, SHALL treat the popped entry as consumed and apply the redirect flush; redirect has priority over push.
REQ-023 On redirect_valid with redirect_pc[1:0]!=0, SHALL flush the buffer, enter FAULT, and latch pc <= redirect_pc.
REQ-024 In FAULT, SHALL hold fault=1 and out_valid=0 and perform no pushes, with r_addr_imem held.
REQ-025 In FAULT, an aligned redirect SHALL return the block to RUN and behave as in REQ-021; a misaligned redirect SHALL keep it in FAULT.
REQ-026 SHALL ignore redirect_pc when redirect_valid=0.

Reset
REQ-027 rst SHALL set pc=RESET_PC, empty the buffer, set state=RUN, and drive out_valid=0 and fault=0; out_instr and out_pc SHALL be 0.
REQ-028 rst asserted mid-operation SHALL take precedence over redirect, push and pop in the same cycle.
REQ-029 The first fetch SHALL occur in the first cycle with rst=0; out_valid SHALL rise one cycle later.

Structure
REQ-030 SHALL place XLEN=32, the RESET_PC default and the fetch state enum in the shared package rv32i_pkg.
REQ-031 SHALL implement the buffer as the sub-module fetch_buf: a DEPTH-entry synchronous FIFO of {pc, instr} with push, pop, flush, full, empty, and registered head.

Verification
REQ-032 The bench SHALL cover: reset release with out_ready=1 and the memory preloaded -> out_pc sequence 0,4,8,12 on consecutive cycles starting in cycle 2, with out_instr matching memory.
REQ-033 The bench SHALL cover: out_ready=0 for 5 cycles -> buffer fills after 2 pushes, r_addr_imem holds at 8, head stays at pc=0; release -> pc 0,4,8 in order with no loss.
REQ-034 The bench SHALL cover: redirect_valid=1 with redirect_pc=0x40 in cycle N -> out_valid=0 in cycle N+1 and out_pc=0x40 in cycle N+2, with no stale pre-redirect word after N.
REQ-035 The bench SHALL cover: redirect to 0x42 -> fault=1 and out_valid=0 from the next cycle; then redirect to 0x80 -> fault=0 and out_pc=0x80 two cycles later.
REQ-036 The bench SHALL cover: redirect to 0xFFFF_FFF8 -> out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-037 The bench SHALL cover: rst pulsed while the buffer is full and a redirect is pending -> next cycle out_valid=0, r_addr_imem=RESET_PC, fault=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the RV32I front end: datapath width, the default
// reset fetch address, the fetch-unit state encoding, the buffered fetch entry
// layout and a small alignment helper.
// -----------------------------------------------------------------------------
package rv32i_pkg;

  localparam int XLEN = 32;

  // First fetch address after reset unless the instance overrides it.
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fixed instruction size; RV32I has no compressed instructions here.
  localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  // One buffered fetch: the address and the word read from it.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// DEPTH-entry synchronous FIFO of {pc, instr} between fetch and decode.
// The head entry is read straight out of the storage registers, so a word
// pushed in one cycle is visible at the head in the next cycle.
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous active-high reset (empties the FIFO)
//   push_i        write pc_i/instr_i this cycle (ignored when full without pop)
//   pc_i          address of the pushed word
//   instr_i       pushed instruction word
//   pop_i         consume the head entry (ignored when empty)
//   flush_i       discard all entries; wins over push and pop
//   full_o        all DEPTH entries occupied
//   empty_o       no entries occupied
//   head_pc_o     address of the head entry, 0 when empty
//   head_instr_o  head instruction word, 0 when empty
// -----------------------------------------------------------------------------
module fetch_buf
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2  // power of two, at least 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [XLEN-1:0] head_pc_o,
  output logic [XLEN-1:0] head_instr_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     head;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // A push into a full FIFO is legal only when the head leaves in the same
  // cycle; the slot it frees is the one the write pointer already points at.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: every signal assigned in always_comb gets a default on entry so no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its inputs as they were before this clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the occupancy count
  // alone decides which entries are meaningful, and the head is masked to 0
  // while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= '{pc: pc_i, instr: instr_i};
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign head_pc_o    = empty_o ? '0 : head.pc;
  assign head_instr_o = empty_o ? '0 : head.instr;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Sequential instruction fetch with a small output buffer and redirect
// support. The PC advances by 4 every cycle the buffer can take a word. A
// redirect flushes the buffer and restarts fetch at the target; a misaligned
// target parks the unit in FAULT until an aligned redirect arrives.
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous active-high reset
//   r_addr_imem     fetch address to instruction memory (the fetch PC)
//   r_data_imem     instruction word for r_addr_imem, same cycle
//   redirect_valid  branch/jump redirect request
//   redirect_pc     redirect target
//   out_valid       buffer head holds a valid instruction
//   out_ready       decode accepts the head this cycle
//   out_instr       head instruction word
//   out_pc          address of out_instr
//   fault           misaligned redirect trapped, fetching halted
// -----------------------------------------------------------------------------
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] r_addr_imem,
  input  logic [XLEN-1:0] r_data_imem,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            fault
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;

  logic buf_full;
  logic buf_empty;
  logic pop;
  logic fetch_en;

  assign pop = out_valid && out_ready;

  // A redirect cancels this cycle's fetch; otherwise fetch whenever a slot is
  // free now or is being freed by the pop in this same cycle.
  assign fetch_en = (state_q == ST_RUN) && !redirect_valid && (!buf_full || pop);

  // Single-block FSM: state and PC move together. The PC wraps naturally
  // at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q    <= redirect_pc;
      state_q <= is_word_aligned(redirect_pc) ? ST_RUN : ST_FAULT;
    end else if (fetch_en) begin
      pc_q    <= pc_q + INSTR_BYTES;
    end
  end

  fetch_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .push_i       (fetch_en),
    .pc_i         (pc_q),
    .instr_i      (r_data_imem),
    .pop_i        (pop),
    .flush_i      (redirect_valid),
    .full_o       (buf_full),
    .empty_o      (buf_empty),
    .head_pc_o    (out_pc),
    .head_instr_o (out_instr)
  );

  // The buffer is flushed on entry to FAULT and never pushed while there, so
  // an empty buffer already keeps out_valid low in that state.
  assign out_valid   = !buf_empty;
  assign r_addr_imem = pc_q;
  assign fault       = (state_q == ST_FAULT);

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch. A reference model turns reset and
// redirect requests into the stream of addresses decode must receive; a
// monitor pops that stream on every handshake and compares. Directed
// sequences check cycle-exact timing; a random phase exercises the rest.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] r_addr_imem;
  logic [31:0] r_data_imem;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address, so every
  // word is distinct and predictable.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  assign r_data_imem = imem_word(r_addr_imem);

  instr_fetch #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .r_addr_imem    (r_addr_imem),
    .r_data_imem    (r_data_imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: decode must see consecutive words starting at the reset
  // PC or the latest aligned redirect target; nothing while faulted.
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc         = 32'h0;
  logic        model_fault    = 1'b0;
  logic [31:0] model_fault_pc = 32'h0;
  logic        seen_reset     = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      gen_pc      = RESET_PC;
      model_fault = 1'b0;
      seen_reset  = 1'b1;
    end else if (redirect_valid) begin
      exp_q.delete();
      if (redirect_pc[1:0] == 2'b00) begin
        gen_pc      = redirect_pc;
        model_fault = 1'b0;
      end else begin
        model_fault    = 1'b1;
        model_fault_pc = redirect_pc;
      end
    end
    if (seen_reset && !model_fault) begin
      while (exp_q.size() < 8) begin
        exp_q.push_back(gen_pc);
        gen_pc = gen_pc + 32'd4;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares every accepted word and the fault/hold behaviour.
  // ---------------------------------------------------------------------------
  logic        hold_pend = 1'b0;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  logic [31:0] mon_exp;

  always @(negedge clk) begin
    if (seen_reset && !rst) begin
      if (hold_pend) begin
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        check("hold_pc", out_pc, hold_pc);
        check("hold_instr", out_instr, hold_instr);
      end
      check("fault_flag", {31'b0, fault}, {31'b0, model_fault});
      if (model_fault) begin
        check("fault_no_valid", {31'b0, out_valid}, 32'd0);
        check("fault_addr_held", r_addr_imem, model_fault_pc);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: out_pc 0x%08h delivered, expected no output (t=%0t)",
                   out_pc, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          check("stream_pc", out_pc, mon_exp);
          check("stream_instr", out_instr, imem_word(mon_exp));
        end
      end
      hold_pend  = out_valid && !out_ready && !redirect_valid;
      hold_pc    = out_pc;
      hold_instr = out_instr;
    end else begin
      hold_pend = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1, the first cycle with rst low.
  task automatic apply_reset(input logic ready);
    tick();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    out_ready      = ready;
    tick();
    rst = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = $urandom();  // must be ignored while redirect_valid=0
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_addr", r_addr_imem, RESET_PC);

    // Reset release with decode ready: out_pc 0,4,8,12 from cycle 2
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("c1_out_valid", {31'b0, out_valid}, 32'd0);
    check("c1_addr", r_addr_imem, RESET_PC);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check("seq_valid", {31'b0, out_valid}, 32'd1);
      check("seq_pc", out_pc, RESET_PC + 32'(4 * i));
      check("seq_instr", out_instr, imem_word(RESET_PC + 32'(4 * i)));
    end

    // Backpressure: buffer fills after two pushes, fetch stalls at 8
    apply_reset(1'b0);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) tick();
      @(negedge clk);
      if (c >= 3) begin
        check("full_addr_hold", r_addr_imem, 32'd8);
        check("full_head_pc", out_pc, 32'd0);
        check("full_head_valid", {31'b0, out_valid}, 32'd1);
      end
    end
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      check("drain_valid", {31'b0, out_valid}, 32'd1);
      check("drain_pc", out_pc, 32'(4 * i));
    end

    // Aligned redirect to 0x40
    redirect_to(32'h0000_0040);
    @(negedge clk);
    check("redir_gap_valid", {31'b0, out_valid}, 32'd0);
    tick();
    @(negedge clk);
    check("redir_target_valid", {31'b0, out_valid}, 32'd1);
    check("redir_target_pc", out_pc, 32'h0000_0040);
    tick();
    @(negedge clk);
    check("redir_next_pc", out_pc, 32'h0000_0044);

    // Misaligned redirect traps; misaligned in FAULT stays; aligned recovers
    redirect_to(32'h0000_0042);
    @(negedge clk);
    check("trap_fault", {31'b0, fault}, 32'd1);
    check("trap_valid", {31'b0, out_valid}, 32'd0);
    check("trap_addr", r_addr_imem, 32'h0000_0042);
    tick();
    @(negedge clk);
    check("trap_fault_hold", {31'b0, fault}, 32'd1);
    redirect_to(32'h0000_0043);
    @(negedge clk);
    check("trap_again_fault", {31'b0, fault}, 32'd1);
    check("trap_again_addr", r_addr_imem, 32'h0000_0043);
    redirect_to(32'h0000_0080);
    @(negedge clk);
    check("recover_fault", {31'b0, fault}, 32'd0);
    check("recover_gap_valid", {31'b0, out_valid}, 32'd0);
    tick();
    @(negedge clk);
    check("recover_valid", {31'b0, out_valid}, 32'd1);
    check("recover_pc", out_pc, 32'h0000_0080);

    // PC wrap at 2^32
    redirect_to(32'hFFFF_FFF8);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("wrap_valid", {31'b0, out_valid}, 32'd1);
      check("wrap_pc", out_pc, 32'hFFFF_FFF8 + 32'(4 * i));
    end

    // Reset while full with a redirect pending: reset wins
    tick();
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    out_ready      = 1'b1;
    tick();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_addr", r_addr_imem, RESET_PC);
    check("midrst_fault", {31'b0, fault}, 32'd0);
    check("midrst_out_pc", out_pc, 32'd0);
    tick();
    @(negedge clk);
    check("midrst_first_pc", out_pc, RESET_PC);

    // Random phase: backpressure, redirects (some misaligned), rare resets
    for (int i = 0; i < 500; i++) begin
      tick();
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_pc    = $urandom();
      redirect_valid = ($urandom_range(0, 15) == 0);
      if (redirect_valid && ($urandom_range(0, 3) != 0)) redirect_pc[1:0] = 2'b00;
      rst = ($urandom_range(0, 199) == 0);
    end
    tick();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    repeat (6) tick();

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
